// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 scancode sequencer: tracks ten held game keys, emits press/release events and start/restart pulses.
// Outputs are registered, one cycle after the strobe cycle; a watchdog abandons stalled E0/F0 prefixes.
module ps2_key_tracker #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clock_fpga,
    input  logic       reset,
    input  logic [7:0] code_in,
    input  logic       code_valid,
    input  logic       clear_keys,
    output logic [9:0] keys_held,
    output logic       key_event,
    output logic [3:0] event_key,
    output logic       event_make,
    output logic       start_pulse,
    output logic       restart_pulse,
    output logic       seq_error
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          code_valid_d;
    logic          byte_stb;
    logic          is_make, is_ext;
    logic          hit;
    logic [3:0]    idx;
    logic [9:0]    keys_nx;
    logic          ev_nx, mk_nx, err_nx;
    logic [3:0]    ek_nx;

    assign byte_stb = code_valid & ~code_valid_d;
    assign is_make  = (state == IDLE) || (state == EXT);
    assign is_ext   = (state == EXT)  || (state == EXT_BRK);

    // Extended and plain codes share byte values, so the prefix selects the table.
    always_comb begin
        hit = 1'b0;
        idx = 4'd0;
        if (!is_ext) begin
            case (code_in)
                8'h76: begin hit = 1'b1; idx = 4'd0; end
                8'h29: begin hit = 1'b1; idx = 4'd1; end
                8'h1D: begin hit = 1'b1; idx = 4'd2; end
                8'h1C: begin hit = 1'b1; idx = 4'd3; end
                8'h1B: begin hit = 1'b1; idx = 4'd4; end
                8'h23: begin hit = 1'b1; idx = 4'd5; end
                default: ;
            endcase
        end else begin
            case (code_in)
                8'h75: begin hit = 1'b1; idx = 4'd6; end
                8'h72: begin hit = 1'b1; idx = 4'd7; end
                8'h6B: begin hit = 1'b1; idx = 4'd8; end
                8'h74: begin hit = 1'b1; idx = 4'd9; end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        keys_nx  = keys_held;
        ev_nx    = 1'b0;
        ek_nx    = event_key;
        mk_nx    = event_make;
        err_nx   = 1'b0;
        if (clear_keys) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            keys_nx  = '0;
        end else if (byte_stb) begin
            cnt_nx = '0;
            if (code_in == 8'hE0) begin
                err_nx   = (state != IDLE);
                state_nx = EXT;
            end else if (code_in == 8'hF0) begin
                if (state == IDLE) begin
                    state_nx = BRK;
                end else if (state == EXT) begin
                    state_nx = EXT_BRK;
                end else begin
                    err_nx   = 1'b1;
                    state_nx = BRK;
                end
            end else begin
                state_nx = IDLE;
                // Typematic repeats and releases of unheld keys fall through silently.
                if (hit && (is_make != keys_held[idx])) begin
                    keys_nx[idx] = is_make;
                    ev_nx        = 1'b1;
                    ek_nx        = idx;
                    mk_nx        = is_make;
                end
            end
        end else if (state != IDLE) begin
            if (cnt == CNT_LAST) begin
                state_nx = IDLE;
                cnt_nx   = '0;
                err_nx   = 1'b1;
            end else begin
                cnt_nx = cnt + 1'b1;
            end
        end
    end

    // code_valid_d follows the input even through reset, so a byte still
    // presented when reset releases is not mistaken for a fresh one.
    always_ff @(posedge clock_fpga) begin
        code_valid_d <= code_valid;
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            keys_held     <= '0;
            key_event     <= 1'b0;
            event_key     <= 4'd0;
            event_make    <= 1'b0;
            start_pulse   <= 1'b0;
            restart_pulse <= 1'b0;
            seq_error     <= 1'b0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            keys_held     <= keys_nx;
            key_event     <= ev_nx;
            event_key     <= ek_nx;
            event_make    <= mk_nx;
            start_pulse   <= ev_nx & mk_nx & (ek_nx == 4'd1);
            restart_pulse <= ev_nx & mk_nx & (ek_nx == 4'd0);
            seq_error     <= err_nx;
        end
    end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences, and randomized bytes vs. a prefix-queue model.
module tb_ps2_key_tracker;

    localparam int T = 16;

    logic       clk = 1'b0;
    logic       reset, code_valid, clear_keys;
    logic [7:0] code_in;
    logic [9:0] keys_held;
    logic       key_event, event_make, start_pulse, restart_pulse, seq_error;
    logic [3:0] event_key;

    ps2_key_tracker #(.TIMEOUT_CYCLES(T)) dut (
        .clock_fpga(clk), .reset(reset), .code_in(code_in), .code_valid(code_valid),
        .clear_keys(clear_keys), .keys_held(keys_held), .key_event(key_event),
        .event_key(event_key), .event_make(event_make), .start_pulse(start_pulse),
        .restart_pulse(restart_pulse), .seq_error(seq_error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] code;
        logic [9:0] keys;
        logic       ev;
        logic [3:0] ek;
        logic       mk;
        logic       st;
        logic       rs;
        logic       er;
    } vec_t;

    int ncmp = 0;
    int nerr = 0;

    logic [7:0] pre[$];
    logic [9:0] m_held;
    logic [7:0] code_tab [10] = '{8'h76, 8'h29, 8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h75, 8'h72, 8'h6B, 8'h74};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t v(input int code, input int keys, input int ev, input int ek,
                               input int mk, input int st, input int rs, input int er);
        vec_t r;
        r.code = 8'(code); r.keys = 10'(keys); r.ev = 1'(ev); r.ek = 4'(ek);
        r.mk = 1'(mk); r.st = 1'(st); r.rs = 1'(rs); r.er = 1'(er);
        return r;
    endfunction

    task automatic check_out(input string tag, input vec_t e);
        chk({tag, "_keys"}, int'(keys_held), int'(e.keys));
        chk({tag, "_event"}, int'(key_event), int'(e.ev));
        if (e.ev) begin
            chk({tag, "_key"}, int'(event_key), int'(e.ek));
            chk({tag, "_make"}, int'(event_make), int'(e.mk));
        end
        chk({tag, "_start"}, int'(start_pulse), int'(e.st));
        chk({tag, "_restart"}, int'(restart_pulse), int'(e.rs));
        chk({tag, "_seqerr"}, int'(seq_error), int'(e.er));
    endtask

    task automatic strobe(input logic [7:0] b);
        code_in    = b;
        code_valid = 1'b1;
        tick();
    endtask

    task automatic release_byte(input int hold, input int gap);
        for (int i = 1; i < hold; i++) begin
            tick();
            chk("hold_quiet", int'(key_event | seq_error), 0);
        end
        code_valid = 1'b0;
        for (int i = 0; i < gap; i++) begin
            tick();
            chk("gap_quiet", int'(key_event | seq_error), 0);
        end
    endtask

    // Prefix bytes are kept as a list; a completing byte reads make/extended off that list.
    task automatic model(input logic [7:0] b, output vec_t e);
        logic ext, brk;
        int   idx;
        e = '0;
        e.code = b;
        if (b == 8'hE0) begin
            if (pre.size() != 0) e.er = 1'b1;
            pre.delete();
            pre.push_back(b);
        end else if (b == 8'hF0) begin
            if (pre.size() == 0 || (pre.size() == 1 && pre[0] == 8'hE0)) begin
                pre.push_back(b);
            end else begin
                e.er = 1'b1;
                pre.delete();
                pre.push_back(b);
            end
        end else begin
            ext = 1'b0;
            brk = 1'b0;
            foreach (pre[i]) begin
                if (pre[i] == 8'hE0) ext = 1'b1;
                else brk = 1'b1;
            end
            pre.delete();
            idx = -1;
            for (int k = 0; k < 10; k++)
                if (code_tab[k] == b && ((k >= 6) == ext)) idx = k;
            if (idx >= 0 && (brk == m_held[idx])) begin
                m_held[idx] = ~brk;
                e.ev = 1'b1;
                e.ek = 4'(idx);
                e.mk = ~brk;
                e.st = ~brk && idx == 1;
                e.rs = ~brk && idx == 0;
            end
        end
        e.keys = m_held;
    endtask

    vec_t tbl[29];
    vec_t e;
    int   pulses, when;

    initial begin
        tbl[0]  = v('h1D, 'h004, 1, 2, 1, 0, 0, 0);
        tbl[1]  = v('hF0, 'h004, 0, 0, 0, 0, 0, 0);
        tbl[2]  = v('h1D, 'h000, 1, 2, 0, 0, 0, 0);
        tbl[3]  = v('hE0, 'h000, 0, 0, 0, 0, 0, 0);
        tbl[4]  = v('h74, 'h200, 1, 9, 1, 0, 0, 0);
        tbl[5]  = v('hE0, 'h200, 0, 0, 0, 0, 0, 0);
        tbl[6]  = v('hF0, 'h200, 0, 0, 0, 0, 0, 0);
        tbl[7]  = v('h74, 'h000, 1, 9, 0, 0, 0, 0);
        tbl[8]  = v('h74, 'h000, 0, 0, 0, 0, 0, 0);
        tbl[9]  = v('h29, 'h002, 1, 1, 1, 1, 0, 0);
        tbl[10] = v('h29, 'h002, 0, 0, 0, 0, 0, 0);
        tbl[11] = v('h76, 'h003, 1, 0, 1, 0, 1, 0);
        tbl[12] = v('h1C, 'h00B, 1, 3, 1, 0, 0, 0);
        tbl[13] = v('hF0, 'h00B, 0, 0, 0, 0, 0, 0);
        tbl[14] = v('hF0, 'h00B, 0, 0, 0, 0, 0, 1);
        tbl[15] = v('h1C, 'h003, 1, 3, 0, 0, 0, 0);
        tbl[16] = v('hE0, 'h003, 0, 0, 0, 0, 0, 0);
        tbl[17] = v('hE0, 'h003, 0, 0, 0, 0, 0, 1);
        tbl[18] = v('h75, 'h043, 1, 6, 1, 0, 0, 0);
        tbl[19] = v('hE0, 'h043, 0, 0, 0, 0, 0, 0);
        tbl[20] = v('hF0, 'h043, 0, 0, 0, 0, 0, 0);
        tbl[21] = v('hF0, 'h043, 0, 0, 0, 0, 0, 1);
        tbl[22] = v('h75, 'h043, 0, 0, 0, 0, 0, 0);
        tbl[23] = v('hE0, 'h043, 0, 0, 0, 0, 0, 0);
        tbl[24] = v('h29, 'h043, 0, 0, 0, 0, 0, 0);
        tbl[25] = v('hAA, 'h043, 0, 0, 0, 0, 0, 0);
        tbl[26] = v('hE0, 'h043, 0, 0, 0, 0, 0, 0);
        tbl[27] = v('hF0, 'h043, 0, 0, 0, 0, 0, 0);
        tbl[28] = v('h75, 'h003, 1, 6, 0, 0, 0, 0);

        reset = 1'b1; code_valid = 1'b0; clear_keys = 1'b0; code_in = 8'h00;
        tick(); tick();
        chk("rst_keys", int'(keys_held), 0);
        chk("rst_outs", int'({key_event, event_key, event_make, start_pulse, restart_pulse, seq_error}), 0);
        reset = 1'b0;
        tick();

        foreach (tbl[i]) begin
            strobe(tbl[i].code);
            check_out($sformatf("tbl%0d", i), tbl[i]);
            release_byte(1, 1);
        end

        // Stalled E0 prefix: one timeout pulse, then a plain decode.
        strobe(8'hE0);
        chk("to_first", int'(seq_error), 0);
        release_byte(1, 1);
        pulses = 0; when = -1;
        for (int i = 1; i <= 2 * T; i++) begin
            tick();
            if (seq_error) begin pulses++; when = i; end
        end
        chk("to_pulses", pulses, 1);
        chk("to_when", when, T - 1);
        strobe(8'h75);
        check_out("to_after", v('h75, 'h003, 0, 0, 0, 0, 0, 0));
        release_byte(1, 2);

        // Byte landing in the timeout cycle wins over the watchdog.
        strobe(8'hE0);
        release_byte(1, 1);
        repeat (T - 2) tick();
        strobe(8'h74);
        check_out("to_race", v('h74, 'h203, 1, 9, 1, 0, 0, 0));
        release_byte(1, T + 2);

        // clear_keys mid-prefix drops the coincident byte and the prefix.
        strobe(8'h1B);
        check_out("clr_s", v('h1B, 'h213, 1, 4, 1, 0, 0, 0));
        release_byte(1, 1);
        strobe(8'hE0);
        release_byte(1, 1);
        strobe(8'h6B);
        check_out("clr_left", v('h6B, 'h313, 1, 8, 1, 0, 0, 0));
        release_byte(1, 1);
        strobe(8'hE0);
        release_byte(1, 1);
        clear_keys = 1'b1; code_in = 8'h6B; code_valid = 1'b1;
        tick();
        check_out("clr_now", v('h6B, 'h000, 0, 0, 0, 0, 0, 0));
        clear_keys = 1'b0;
        release_byte(1, 1);
        strobe(8'h6B);
        check_out("clr_next", v('h6B, 'h000, 0, 0, 0, 0, 0, 0));
        release_byte(1, 3);

        // Reset with a byte held on code_valid.
        strobe(8'h1D);
        check_out("rv_w", v('h1D, 'h004, 1, 2, 1, 0, 0, 0));
        release_byte(1, 1);
        strobe(8'hE0);
        release_byte(1, 1);
        reset = 1'b1; code_in = 8'h1C; code_valid = 1'b1;
        tick();
        chk("rv_keys", int'(keys_held), 0);
        chk("rv_outs", int'({key_event, event_key, event_make, start_pulse, restart_pulse, seq_error}), 0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rv_held", int'({keys_held, key_event}), 0);
        end
        code_valid = 1'b0;
        tick();
        strobe(8'h74);
        check_out("rv_plain74", v('h74, 'h000, 0, 0, 0, 0, 0, 0));
        release_byte(1, 1);
        strobe(8'h1C);
        check_out("rv_a", v('h1C, 'h008, 1, 3, 1, 0, 0, 0));
        release_byte(1, 1);

        // Randomized bytes against the model.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        pre.delete();
        m_held = '0;
        for (int n = 0; n < 400; n++) begin
            int r;
            logic [7:0] b;
            if ($urandom_range(0, 19) == 0) begin
                clear_keys = 1'b1;
                tick();
                clear_keys = 1'b0;
                pre.delete();
                m_held = '0;
                chk("rnd_clear", int'({keys_held, key_event, seq_error}), 0);
            end
            r = int'($urandom_range(0, 15));
            if (r <= 2)       b = 8'hE0;
            else if (r <= 4)  b = 8'hF0;
            else if (r <= 13) b = code_tab[$urandom_range(0, 9)];
            else if (r == 14) b = 8'hAA;
            else              b = 8'($urandom);
            model(b, e);
            strobe(b);
            check_out($sformatf("rnd%0d_%02h", n, b), e);
            release_byte(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
